// File: rtl/aes_decryption_iter.sv
// -----------------------------------------------------------------------------
// aes_decryption_iter_pkg / aes_sbox / aes_inv_sbox / aes_decryption_iter
//
// Iterative AES-128 inverse cipher, one round per clock. The cipher key is
// expanded into an internal 11-entry round-key file (one key word group per
// cycle), and 128-bit ciphertext blocks are then decrypted under valid/ready
// handshakes.
//
// Byte order: state byte i = bits[8i+7:8i] (LSB-first), column c = bytes
// 4c..4c+3, and row r of column c = byte 4c+r.
//
// Ports (aes_decryption_iter):
//   clk         in   1    clock, rising edge
//   rst         in   1    asynchronous, active-high reset
//   key_in      in   128  cipher key (round key 0), sampled on key handshake
//   key_valid   in   1    key offer (takes priority over in_valid)
//   key_ready   out  1    high in IDLE only
//   data_in     in   128  ciphertext, sampled on input handshake
//   in_valid    in   1    ciphertext offer
//   in_ready    out  1    IDLE & key_loaded & ~key_valid
//   plain_out   out  128  plaintext, stable while out_valid is high
//   out_valid   out  1    plaintext available
//   out_ready   in   1    consumer accepts plaintext
//   key_loaded  out  1    round-key file is valid
//   busy        out  1    FSM not in IDLE
// -----------------------------------------------------------------------------

package aes_decryption_iter_pkg;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Round constant for expansion step i (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Row r of the state is rotated right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    return o;
  endfunction

endpackage

// Forward S-box: affine transform of the GF(2^8) inverse.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_decryption_iter_pkg::*;

  logic [7:0] inv;

  assign inv = gf_inv(a);
  assign y   = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform, then GF(2^8) inverse.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_decryption_iter_pkg::*;

  logic [7:0] pre;

  assign pre = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
  assign y   = gf_inv(pre);
endmodule

module aes_decryption_iter #(
  parameter int NR         = 10,   // AES-128 only; other values are not supported
  parameter bit KEY_RETAIN = 1'b1  // 0: key_loaded drops after each output handshake
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] plain_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         key_loaded,
  output logic         busy
);
  import aes_decryption_iter_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   rk_q [0:NR];
  logic [127:0]   st_q;
  logic [127:0]   plain_q;
  logic           out_valid_q;
  logic           key_loaded_q;
  // Expansion index in KEXP, round index in DEC.
  logic [3:0]     cnt_q;

  logic           key_hs, in_hs;
  logic [127:0]   rk_prev, rk_next, rk_dec;
  logic [31:0]    rot_w, sub_w, t_w;
  logic [127:0]   isr, isb, ark, imc;

  assign key_ready  = (state_q == S_IDLE);
  assign in_ready   = (state_q == S_IDLE) & key_loaded_q & ~key_valid;
  assign key_hs     = key_valid & key_ready;
  assign in_hs      = in_valid & in_ready;
  assign plain_out  = plain_q;
  assign out_valid  = out_valid_q;
  assign key_loaded = key_loaded_q;
  assign busy       = (state_q != S_IDLE);

  // Round-key selection: rk[cnt-1] feeds expansion, rk[cnt] feeds decryption.
  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rk_prev = rk_q[0];
    rk_dec  = rk_q[0];
    for (int i = 0; i < NR; i++) begin
      if (cnt_q == 4'(i + 1)) rk_prev = rk_q[i];
    end
    for (int i = 0; i <= NR; i++) begin
      if (cnt_q == 4'(i)) rk_dec = rk_q[i];
    end
  end

  // Forward key expansion of the previous round key: 4 S-box lookups.
  assign rot_w = {rk_prev[103:96], rk_prev[127:104]};

  for (genvar i = 0; i < 4; i++) begin : g_kexp_sbox
    aes_sbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .y (sub_w[8*i +: 8])
    );
  end

  assign t_w = sub_w ^ {24'h0, rcon(cnt_q)};

  always_comb begin
    rk_next           = '0;
    rk_next[31:0]     = rk_prev[31:0]   ^ t_w;
    rk_next[63:32]    = rk_prev[63:32]  ^ rk_next[31:0];
    rk_next[95:64]    = rk_prev[95:64]  ^ rk_next[63:32];
    rk_next[127:96]   = rk_prev[127:96] ^ rk_next[95:64];
  end

  // Inverse round datapath: 16 inverse S-box lookups.
  assign isr = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_dec_sbox
    aes_inv_sbox u_inv_sbox (
      .a (isr[8*i +: 8]),
      .y (isb[8*i +: 8])
    );
  end

  assign ark = isb ^ rk_dec;
  assign imc = inv_mix_columns(ark);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (key_hs)     state_d = S_KEXP;
        else if (in_hs) state_d = S_DEC;
      end
      S_KEXP:  if (cnt_q == 4'(NR)) state_d = S_IDLE;
      S_DEC:   if (cnt_q == 4'd0)   state_d = S_DONE;
      S_DONE:  if (out_ready)       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // NOTE: the round-key file is cleared on reset so a partially expanded
      // key never survives an aborted load.
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      st_q         <= '0;
      plain_q      <= '0;
      out_valid_q  <= 1'b0;
      key_loaded_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (key_hs) begin
            rk_q[0]      <= key_in;
            key_loaded_q <= 1'b0;
            cnt_q        <= 4'd1;
          end else if (in_hs) begin
            st_q  <= data_in ^ rk_q[NR];
            cnt_q <= 4'(NR - 1);
          end
        end
        S_KEXP: begin
          for (int i = 1; i <= NR; i++) begin
            if (cnt_q == 4'(i)) rk_q[i] <= rk_next;
          end
          if (cnt_q == 4'(NR)) begin
            key_loaded_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DEC: begin
          if (cnt_q == 4'd0) begin
            plain_q     <= ark;
            out_valid_q <= 1'b1;
          end else begin
            st_q  <= imc;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!KEY_RETAIN) key_loaded_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
